minv_flag_bank: RTL and testbench

- Multi-channel successor to the single-bit minv location flag.
- Tracks, for NCH concurrent modular-inversion channels, which of NREG working registers holds each channel's minv, with per-cycle write and rotate (swap) updates.
- On channel completion, freezes (locks) that channel and queues {channel, location} for the downstream consumer over a valid/ready interface.
- Sits between the inversion datapath controllers and the result-readout/writeback stage.

---
 rtl/minv_flag_bank_if.sv | 47 ++++
 rtl/minv_flag_bank.sv | 136 +++++++++++++
 tb/tb_minv_flag_bank.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/minv_flag_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : minv_flag_bank_if
// Purpose  : Bundles the request side and the completion-queue side of the
//            minv flag bank into one port.
//            master : inversion controllers and readout stage. Drives wr_*,
//                     rot_*, done_* and out_ready.
//            slave  : minv_flag_bank. Drives flag_out, lock_out, out_valid,
//                     out_ch, out_flag, q_count and err.
// Revision : 1.0 - initial release
// ============================================================================
interface minv_flag_bank_if #(
  parameter int NCH    = 4,
  parameter int NREG   = 2,
  parameter int QDEPTH = 4
);
  localparam int CW = (NCH  > 1) ? $clog2(NCH)  : 1;
  localparam int FW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int QW = $clog2(QDEPTH) + 1;

  logic              wr_en;
  logic [CW-1:0]     wr_ch;
  logic [FW-1:0]     wr_data;
  logic              rot_en;
  logic [CW-1:0]     rot_ch;
  logic              done_en;
  logic [CW-1:0]     done_ch;
  logic [NCH*FW-1:0] flag_out;
  logic [NCH-1:0]    lock_out;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     out_ch;
  logic [FW-1:0]     out_flag;
  logic [QW-1:0]     q_count;
  logic              err;

  modport master (
    output wr_en, wr_ch, wr_data, rot_en, rot_ch, done_en, done_ch, out_ready,
    input  flag_out, lock_out, out_valid, out_ch, out_flag, q_count, err
  );

  modport slave (
    input  wr_en, wr_ch, wr_data, rot_en, rot_ch, done_en, done_ch, out_ready,
    output flag_out, lock_out, out_valid, out_ch, out_flag, q_count, err
  );
endinterface
`default_nettype wire

// File: rtl/minv_flag_bank.sv
`default_nettype none
// ============================================================================
// Module   : minv_flag_bank
// Purpose  : Tracks, for NCH modular-inversion channels, which of NREG
//            working registers holds each channel's minv. Per-cycle load and
//            rotate updates are applied to unlocked channels. A completing
//            channel is locked and {channel, location} is queued for the
//            readout stage. Popping the entry releases the lock.
// Ports    : clk, rst   - clock and synchronous active-high reset
//            bus (slave)- wr_*/rot_*/done_* requests, out_valid/out_ready
//                         completion queue, flag_out, lock_out, q_count, err
// Revision : 1.0 - initial release
// ============================================================================
module minv_flag_bank #(
  parameter int NCH    = 4,
  parameter int NREG   = 2,
  parameter int QDEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  minv_flag_bank_if.slave bus
);
  localparam int CW = (NCH  > 1) ? $clog2(NCH)  : 1;
  localparam int FW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int AW = $clog2(QDEPTH);
  localparam int QW = AW + 1;
  localparam logic [FW-1:0] FLAG_MAX = FW'(NREG - 1);
  localparam logic [FW:0]   NREG_V   = (FW + 1)'(NREG);
  localparam logic [QW-1:0] QFULL    = QW'(QDEPTH);

  logic [FW-1:0]  r_flag   [NCH];
  logic [NCH-1:0] r_lock;
  logic [CW-1:0]  r_q_ch   [QDEPTH];
  logic [FW-1:0]  r_q_flag [QDEPTH];
  logic [AW-1:0]  r_rd_ptr;
  logic [AW-1:0]  r_wr_ptr;
  logic [QW-1:0]  r_count;
  logic           r_err;

  logic           w_wr_ok;
  logic           w_rot_ok;
  logic           w_pop;
  logic           w_space;
  logic           w_push;
  logic           w_reject;
  logic [CW-1:0]  w_head_ch;
  logic [FW-1:0]  w_flag_nxt [NCH];
  logic [NCH-1:0] w_lock_nxt;

  // All acceptance decisions look at the registered lock, so a request to a
  // channel whose entry pops this cycle is still refused.
  assign w_head_ch = r_q_ch[r_rd_ptr];
  assign w_pop     = (r_count != '0) && bus.out_ready;
  assign w_wr_ok   = bus.wr_en && ({1'b0, bus.wr_data} < NREG_V) && !r_lock[bus.wr_ch];
  assign w_rot_ok  = bus.rot_en && !r_lock[bus.rot_ch];
  // A full queue still has room when the head leaves in the same cycle.
  assign w_space   = (r_count != QFULL) || w_pop;
  assign w_push    = bus.done_en && !r_lock[bus.done_ch] && w_space;
  assign w_reject  = (bus.wr_en && !w_wr_ok) || (bus.rot_en && !w_rot_ok) ||
                     (bus.done_en && !w_push);

  // Accepted load beats rotate on the same channel; a refused load does not
  // block a rotate that is itself legal.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_flag_nxt[i] = r_flag[i];
      if (w_wr_ok && (bus.wr_ch == CW'(i))) begin
        w_flag_nxt[i] = bus.wr_data;
      end else if (w_rot_ok && (bus.rot_ch == CW'(i))) begin
        w_flag_nxt[i] = (r_flag[i] == FLAG_MAX) ? '0 : r_flag[i] + 1'b1;
      end
    end
  end

  // The pushed channel is unlocked and the head channel is locked, so the
  // set and clear never target the same bit.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_lock_nxt[i] = r_lock[i];
      if (w_push && (bus.done_ch == CW'(i))) begin
        w_lock_nxt[i] = 1'b1;
      end else if (w_pop && (w_head_ch == CW'(i))) begin
        w_lock_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_flag[i] <= '0;
      end
      r_lock   <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_flag <= w_flag_nxt;
      r_lock <= w_lock_nxt;
      r_err  <= w_reject;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: it is only observed through out_valid.
  // The stored location includes any same-cycle load/rotate of the channel.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_q_ch[r_wr_ptr]   <= bus.done_ch;
      r_q_flag[r_wr_ptr] <= w_flag_nxt[bus.done_ch];
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_flag_out
    assign bus.flag_out[g*FW +: FW] = r_flag[g];
  end

  assign bus.lock_out  = r_lock;
  assign bus.out_valid = (r_count != '0);
  assign bus.out_ch    = bus.out_valid ? w_head_ch : '0;
  assign bus.out_flag  = bus.out_valid ? r_q_flag[r_rd_ptr] : '0;
  assign bus.q_count   = r_count;
  assign bus.err       = r_err;
endmodule
`default_nettype wire

// File: tb/tb_minv_flag_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_minv_flag_bank
// Purpose  : Self-checking bench for minv_flag_bank. Instance A uses the
//            default sizing (NCH=4, NREG=2, QDEPTH=4). Instance B uses
//            NCH=8, NREG=3, QDEPTH=4 for rotate wrap, out-of-range loads and
//            the full-queue drop. A directed sequence is followed by a
//            randomized run. Both instances are compared every cycle against
//            a list-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_minv_flag_bank;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  minv_flag_bank_if #(.NCH(4), .NREG(2), .QDEPTH(4)) ifa ();
  minv_flag_bank_if #(.NCH(8), .NREG(3), .QDEPTH(4)) ifb ();

  minv_flag_bank #(.NCH(4), .NREG(2), .QDEPTH(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  minv_flag_bank #(.NCH(8), .NREG(3), .QDEPTH(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int checks = 0;
  int errors = 0;

  // Behavioural model: per-instance flags, locks, ordered entry list, err.
  int m_flag [2][8];
  bit m_lock [2][8];
  int m_ech  [2][8];
  int m_efl  [2][8];
  int m_n    [2];
  bit m_err  [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input int k, input int nch, input int nreg, input int qd,
                            input bit rst_i, input bit wr_en, input int wr_ch, input int wr_data,
                            input bit rot_en, input int rot_ch, input bit done_en, input int done_ch,
                            input bit out_ready);
    int nf [8];
    bit nl [8];
    bit rej, pop, space, wr_acc;
    if (rst_i) begin
      for (int i = 0; i < 8; i++) begin
        m_flag[k][i] = 0;
        m_lock[k][i] = 0;
      end
      m_n[k]   = 0;
      m_err[k] = 0;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      nf[i] = m_flag[k][i];
      nl[i] = m_lock[k][i];
    end
    rej    = 0;
    pop    = (m_n[k] > 0) && out_ready;
    space  = (m_n[k] < qd) || pop;
    wr_acc = wr_en && (wr_data < nreg) && !m_lock[k][wr_ch];
    if (wr_en && !wr_acc) rej = 1;
    if (wr_acc) nf[wr_ch] = wr_data;
    if (rot_en) begin
      if (m_lock[k][rot_ch]) rej = 1;
      else if (!(wr_acc && wr_ch == rot_ch)) nf[rot_ch] = (m_flag[k][rot_ch] + 1) % nreg;
    end
    if (pop) begin
      nl[m_ech[k][0]] = 0;
      for (int i = 0; i < 7; i++) begin
        m_ech[k][i] = m_ech[k][i+1];
        m_efl[k][i] = m_efl[k][i+1];
      end
      m_n[k]--;
    end
    if (done_en) begin
      if (m_lock[k][done_ch] || !space) begin
        rej = 1;
      end else begin
        m_ech[k][m_n[k]] = done_ch;
        m_efl[k][m_n[k]] = nf[done_ch];
        m_n[k]++;
        nl[done_ch] = 1;
      end
    end
    for (int i = 0; i < nch; i++) begin
      m_flag[k][i] = nf[i];
      m_lock[k][i] = nl[i];
    end
    m_err[k] = rej;
  endtask

  task automatic check(input int k, input int nch, input int fw, input string nm,
                       input logic [31:0] flags, input logic [31:0] locks, input logic [31:0] valid,
                       input logic [31:0] och, input logic [31:0] ofl, input logic [31:0] cnt,
                       input logic [31:0] err);
    logic [31:0] ef, el;
    ef = 0;
    el = 0;
    for (int i = 0; i < nch; i++) begin
      ef = ef | (32'(m_flag[k][i]) << (i * fw));
      el = el | (32'(m_lock[k][i]) << i);
    end
    chk({nm, ".flag_out"}, flags, ef);
    chk({nm, ".lock_out"}, locks, el);
    chk({nm, ".out_valid"}, valid, 32'(m_n[k] != 0));
    chk({nm, ".out_ch"}, och, (m_n[k] != 0) ? 32'(m_ech[k][0]) : 32'd0);
    chk({nm, ".out_flag"}, ofl, (m_n[k] != 0) ? 32'(m_efl[k][0]) : 32'd0);
    chk({nm, ".q_count"}, cnt, 32'(m_n[k]));
    chk({nm, ".err"}, err, 32'(m_err[k]));
  endtask

  task automatic tick();
    model_step(0, 4, 2, 4, rst, ifa.wr_en, int'(ifa.wr_ch), int'(ifa.wr_data), ifa.rot_en,
               int'(ifa.rot_ch), ifa.done_en, int'(ifa.done_ch), ifa.out_ready);
    model_step(1, 8, 3, 4, rst, ifb.wr_en, int'(ifb.wr_ch), int'(ifb.wr_data), ifb.rot_en,
               int'(ifb.rot_ch), ifb.done_en, int'(ifb.done_ch), ifb.out_ready);
    @(posedge clk);
    #1;
    check(0, 4, 1, "a", 32'(ifa.flag_out), 32'(ifa.lock_out), 32'(ifa.out_valid),
          32'(ifa.out_ch), 32'(ifa.out_flag), 32'(ifa.q_count), 32'(ifa.err));
    check(1, 8, 2, "b", 32'(ifb.flag_out), 32'(ifb.lock_out), 32'(ifb.out_valid),
          32'(ifb.out_ch), 32'(ifb.out_flag), 32'(ifb.q_count), 32'(ifb.err));
  endtask

  task automatic set_a(input int we, input int wc, input int wd, input int re, input int rc,
                       input int de, input int dc, input int rdy);
    ifa.wr_en     = we[0];
    ifa.wr_ch     = wc[1:0];
    ifa.wr_data   = wd[0:0];
    ifa.rot_en    = re[0];
    ifa.rot_ch    = rc[1:0];
    ifa.done_en   = de[0];
    ifa.done_ch   = dc[1:0];
    ifa.out_ready = rdy[0];
  endtask

  task automatic set_b(input int we, input int wc, input int wd, input int re, input int rc,
                       input int de, input int dc, input int rdy);
    ifb.wr_en     = we[0];
    ifb.wr_ch     = wc[2:0];
    ifb.wr_data   = wd[1:0];
    ifb.rot_en    = re[0];
    ifb.rot_ch    = rc[2:0];
    ifb.done_en   = de[0];
    ifb.done_ch   = dc[2:0];
    ifb.out_ready = rdy[0];
  endtask

  initial begin
    rst = 1'b1;
    set_a(0, 0, 0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;

    // Instance A: load, then rotate+done on ch3 in one cycle.
    set_a(1, 2, 1, 0, 0, 0, 0, 0); tick();
    set_a(0, 0, 0, 0, 0, 0, 0, 0); tick();
    set_a(0, 0, 0, 1, 3, 1, 3, 0); tick();
    set_a(1, 3, 0, 0, 0, 0, 0, 0); tick();
    set_a(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    // Pop with a same-cycle load to the still-locked channel, then a legal load.
    set_a(1, 3, 0, 0, 0, 0, 0, 1); tick();
    set_a(1, 3, 0, 0, 0, 0, 0, 0); tick();
    // Fill the queue, then pop the head while re-completing its channel.
    for (int c = 0; c < 4; c++) begin
      set_a(0, 0, 0, 0, 0, 1, c, 0); tick();
    end
    set_a(0, 0, 0, 0, 0, 1, 0, 1); tick();
    set_a(0, 0, 0, 0, 0, 0, 0, 0); tick();
    // Reset with three entries queued.
    rst = 1'b1; tick();
    rst = 1'b0; tick();

    // Instance B: rotate wrap at NREG=3, load priority, out-of-range load.
    for (int i = 0; i < 3; i++) begin
      set_b(0, 0, 0, 1, 0, 0, 0, 0); tick();
    end
    set_b(1, 0, 1, 1, 0, 0, 0, 0); tick();
    set_b(1, 1, 3, 0, 0, 0, 0, 0); tick();
    // Fill, then a done on an unlocked channel with no pop is dropped.
    for (int c = 0; c < 4; c++) begin
      set_b(0, 0, 0, 0, 0, 1, c, 0); tick();
    end
    set_b(0, 0, 0, 0, 0, 1, 5, 0); tick();
    set_b(0, 0, 0, 0, 0, 0, 0, 0); tick();
    rst = 1'b1; tick();
    rst = 1'b0; tick();

    // Randomized traffic on both instances.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      set_a(($urandom_range(0, 2) == 0), $urandom_range(0, 3), $urandom_range(0, 1),
            ($urandom_range(0, 2) == 0), $urandom_range(0, 3),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, 1));
      set_b(($urandom_range(0, 2) == 0), $urandom_range(0, 7), $urandom_range(0, 3),
            ($urandom_range(0, 2) == 0), $urandom_range(0, 7),
            ($urandom_range(0, 2) == 0), $urandom_range(0, 7), ($urandom_range(0, 2) == 0));
      tick();
    end
    rst = 1'b0;
    set_a(0, 0, 0, 0, 0, 0, 0, 1);
    set_b(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
